// File: rtl/xor_descr_pkg.sv
// rtl/xor_descr_pkg.sv - shared constants, types and reference scrambler for the PRBS7 descrambler
//
// Contents:
//   BYTE_W, HIST_W, TAP_A, TAP_B, CNT_W  - datapath and history geometry
//   descr_state_t                         - FILL / LOCKED lock state
//   scr_res_t                             - scrambled byte plus the scrambler history after it
//   golden_scramble_byte(d, hist)         - transmit-side x^7 + x^6 + 1 scrambler, MSB first
package xor_descr_pkg;

    localparam int BYTE_W = 8;
    localparam int HIST_W = 7;
    localparam int TAP_A  = 5;
    localparam int TAP_B  = 6;
    localparam int CNT_W  = 4;

    typedef enum logic {
        FILL   = 1'b0,
        LOCKED = 1'b1
    } descr_state_t;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic [BYTE_W-1:0] data;
    } scr_res_t;

    // Self-synchronising scrambler: the history holds transmitted
    // (scrambled) bits, which is what lets the receiver recover
    // without any seed exchange.
    function automatic scr_res_t golden_scramble_byte(input logic [BYTE_W-1:0] d,
                                                      input logic [HIST_W-1:0] hist);
        scr_res_t          r;
        logic [HIST_W-1:0] h;
        logic              s;
        h = hist;
        r = '0;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            s         = d[i] ^ h[TAP_A] ^ h[TAP_B];
            r.data[i] = s;
            h         = {h[HIST_W-2:0], s};
        end
        r.hist = h;
        return r;
    endfunction

endpackage

// File: rtl/xor_descrambler_if.sv
// rtl/xor_descrambler_if.sv - byte stream handshake bundle (data/valid/ready)
//
// Signals:
//   data   - 8-bit byte, bit 7 first in time
//   valid  - producer has a byte
//   ready  - consumer takes the byte when valid && ready
// Modports:
//   master - drives data/valid, observes ready
//   slave  - observes data/valid, drives ready
interface xor_descrambler_if;
    import xor_descr_pkg::*;

    logic [BYTE_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/xor_descr_byte.sv
// rtl/xor_descr_byte.sv - combinational 8-bit PRBS7 descrambler step
//
// Ports:
//   in_byte   in   scrambled byte, bit 7 first in time
//   hist      in   history before this byte (most recent bit in hist[0])
//   out_byte  out  descrambled byte
//   hist_next out  history after shifting in all eight received bits
module xor_descr_byte
    import xor_descr_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    input  logic [HIST_W-1:0] hist,
    output logic [BYTE_W-1:0] out_byte,
    output logic [HIST_W-1:0] hist_next
);

    logic [HIST_W-1:0] h;

    // The history always takes the received bit, never the recovered one;
    // that is what makes the receiver self-synchronise to the transmitter.
    always_comb begin
        h        = hist;
        out_byte = '0;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            out_byte[i] = in_byte[i] ^ h[TAP_A] ^ h[TAP_B];
            h           = {h[HIST_W-2:0], in_byte[i]};
        end
        hist_next = h;
    end

endmodule

// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - PRBS7 (x^7 + x^6 + 1) byte-stream descrambler with fill/lock FSM
//
// Optional build macro: XOR_DESCR_BYPASS_EN (adds the bypass input).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   sync_clr  in   re-sync request: clears history, drops pending output, back to FILL
//   bypass    in   (XOR_DESCR_BYPASS_EN only) pass bytes through unchanged, emit during FILL too
//   s_if      slave  scrambled input stream from the deserialiser
//   m_if      master descrambled output stream to the byte consumer
//   locked    out  high while in LOCKED
//
// Parameters:
//   SYNC_BYTES  bytes discarded after reset/sync_clr while the history fills (1..15)
//   DATA_W      byte width, must be 8
module xor_descrambler
    import xor_descr_pkg::*;
#(
    parameter int SYNC_BYTES = 1,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_clr,
`ifdef XOR_DESCR_BYPASS_EN
    input  logic              bypass,
`endif
    xor_descrambler_if.slave  s_if,
    xor_descrambler_if.master m_if,
    output logic              locked
);

    if (DATA_W != BYTE_W) begin : g_bad_width
        $error("xor_descrambler: DATA_W must be 8");
    end
    if (SYNC_BYTES < 1 || SYNC_BYTES > 15) begin : g_bad_sync
        $error("xor_descrambler: SYNC_BYTES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_BYTES);

    descr_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [HIST_W-1:0] hist_step;
    logic [BYTE_W-1:0] desc_byte;
    logic [BYTE_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              bypass_w;
    logic              in_fill;
    logic              accept;

`ifdef XOR_DESCR_BYPASS_EN
    assign bypass_w = bypass;
`else
    assign bypass_w = 1'b0;
`endif

    xor_descr_byte u_step (
        .in_byte   (s_if.data),
        .hist      (hist_q),
        .out_byte  (desc_byte),
        .hist_next (hist_step)
    );

    assign in_fill = (state_q == FILL);

    // In FILL nothing is emitted, so input never has to wait on the output
    // register. With bypass the fill bytes are emitted, so the normal
    // pop-through rule applies to keep m_data stable under backpressure.
    assign s_if.ready = !m_valid_q || m_if.ready || (in_fill && !bypass_w);
    assign accept     = s_if.valid && s_if.ready;

    // Saturating fill counter increment.
    assign cnt_inc = (cnt_q == SYNC_CNT) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            hist_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hist_q    <= hist_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hist_d    = hist_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;

        if (sync_clr) begin
            // Re-sync wins over a same-cycle transfer; that byte is acked and lost.
            state_d   = FILL;
            cnt_d     = '0;
            hist_d    = '0;
            m_valid_d = 1'b0;
        end else begin
            if (m_valid_q && m_if.ready) begin
                m_valid_d = 1'b0;
            end
            if (accept) begin
                hist_d = hist_step;
                if (in_fill) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SYNC_CNT) begin
                        state_d = LOCKED;
                    end
                end
                // A same-cycle pop and accept simply overwrites the register.
                if (!in_fill || bypass_w) begin
                    m_data_d  = bypass_w ? s_if.data : desc_byte;
                    m_valid_d = 1'b1;
                end
            end
        end
    end

    assign m_if.data  = m_data_q;
    assign m_if.valid = m_valid_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - directed self-checking bench for xor_descrambler
module tb_xor_descrambler;
    import xor_descr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_clr = 1'b0;
`ifdef XOR_DESCR_BYPASS_EN
    logic bypass = 1'b0;
`endif
    logic locked;

    xor_descrambler_if s_if ();
    xor_descrambler_if m_if ();

    int total = 0;
    int bad   = 0;

    logic              rdy_seen;
    logic [HIST_W-1:0] scr_hist;
    logic [31:0]       seed = 32'h1234_5678;

    always #5 clk = ~clk;

    xor_descrambler #(.SYNC_BYTES(1), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_clr (sync_clr),
`ifdef XOR_DESCR_BYPASS_EN
        .bypass   (bypass),
`endif
        .s_if     (s_if),
        .m_if     (m_if),
        .locked   (locked)
    );

    // Drive one cycle of inputs, capture s_ready before the edge, then settle after it.
    task automatic step(input logic [7:0] d, input logic v, input logic mr, input logic sc);
        s_if.data  = d;
        s_if.valid = v;
        m_if.ready = mr;
        sync_clr   = sc;
        #1;
        rdy_seen = s_if.ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] next_rand();
        seed = seed * 32'd1103515245 + 32'd12345;
        return seed[23:16];
    endfunction

    // Scramble one payload byte against the bench's own transmitter history.
    function automatic logic [7:0] scr(input logic [7:0] p);
        scr_res_t r;
        r        = golden_scramble_byte(p, scr_hist);
        scr_hist = r.hist;
        return r.data;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got %b want 0", m_if.valid); end
        total++; if (m_if.data !== 8'h00) begin bad++; $display("FAIL reset_m_data got %h want 00", m_if.data); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got %b want 0", locked); end
        total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL reset_s_ready got %b want 1", rdy_seen); end
    endtask

    task automatic test_first_bytes(input string tag);
        step(8'h00, 1'b1, 1'b1, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL %s_lock got %b want 1", tag, locked); end
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL %s_sync_dropped got %b want 0", tag, m_if.valid); end
        step(8'hFF, 1'b1, 1'b1, 1'b0);
        total++; if (m_if.valid !== 1'b1) begin bad++; $display("FAIL %s_ff_valid got %b want 1", tag, m_if.valid); end
        total++; if (m_if.data !== 8'hFD) begin bad++; $display("FAIL %s_ff_data got %h want fd", tag, m_if.data); end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL %s_pop got %b want 0", tag, m_if.valid); end
    endtask

    task automatic test_zero_stream();
        step(8'h00, 1'b0, 1'b1, 1'b1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL zero_clr_locked got %b want 0", locked); end
        step(8'h00, 1'b1, 1'b1, 1'b0);
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL zero_sync_dropped got %b want 0", m_if.valid); end
        for (int i = 0; i < 64; i++) begin
            step(8'h00, 1'b1, 1'b1, 1'b0);
            total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL zero_ready[%0d] got %b want 1", i, rdy_seen); end
            total++; if (m_if.valid !== 1'b1) begin bad++; $display("FAIL zero_valid[%0d] got %b want 1", i, m_if.valid); end
            total++; if (m_if.data !== 8'h00) begin bad++; $display("FAIL zero_data[%0d] got %h want 00", i, m_if.data); end
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_payload();
        logic [7:0] p;
        step(8'h00, 1'b0, 1'b1, 1'b1);
        scr_hist = '0;
        for (int i = 0; i <= 200; i++) begin
            p = next_rand();
            step(scr(p), 1'b1, 1'b1, 1'b0);
            if (i == 0) begin
                total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL payload_sync_dropped got %b want 0", m_if.valid); end
            end else begin
                total++; if (m_if.valid !== 1'b1) begin bad++; $display("FAIL payload_valid[%0d] got %b want 1", i, m_if.valid); end
                total++; if (m_if.data !== p) begin bad++; $display("FAIL payload_data[%0d] got %h want %h", i, m_if.data, p); end
            end
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] s1;
        step(scr(8'hA5), 1'b1, 1'b0, 1'b0);
        total++; if (m_if.data !== 8'hA5) begin bad++; $display("FAIL bp_first got %h want a5", m_if.data); end
        s1 = scr(8'h3C);
        for (int i = 0; i < 3; i++) begin
            step(s1, 1'b1, 1'b0, 1'b0);
            total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b want 0", i, rdy_seen); end
            total++; if (m_if.valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, m_if.valid); end
            total++; if (m_if.data !== 8'hA5) begin bad++; $display("FAIL bp_hold[%0d] got %h want a5", i, m_if.data); end
        end
        step(s1, 1'b1, 1'b1, 1'b0);
        total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", rdy_seen); end
        total++; if (m_if.data !== 8'h3C) begin bad++; $display("FAIL bp_second got %h want 3c", m_if.data); end
        step(scr(8'h7E), 1'b1, 1'b1, 1'b0);
        total++; if (m_if.data !== 8'h7E) begin bad++; $display("FAIL bp_third got %h want 7e", m_if.data); end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", m_if.valid); end
    endtask

    task automatic test_sync_clr();
        logic [7:0] p;
        step(8'h00, 1'b0, 1'b1, 1'b1);
        scr_hist = '0;
        for (int i = 0; i < 60; i++) begin
            p = next_rand();
            if (i == 51) scr_hist = '0;
            step(scr(p), 1'b1, 1'b1, (i == 50));
            if (i == 50) begin
                total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL clr_ack got %b want 1", rdy_seen); end
                total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL clr_valid got %b want 0", m_if.valid); end
                total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_locked got %b want 0", locked); end
            end else if (i == 0 || i == 51) begin
                total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL clr_drop[%0d] got %b want 0", i, m_if.valid); end
                total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_relock[%0d] got %b want 1", i, locked); end
            end else begin
                total++; if (m_if.data !== p || m_if.valid !== 1'b1) begin bad++; $display("FAIL clr_data[%0d] got %h/%b want %h/1", i, m_if.data, m_if.valid, p); end
            end
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        step(scr(8'h11), 1'b1, 1'b1, 1'b0);
        step(scr(8'h22), 1'b1, 1'b1, 1'b0);
        total++; if (m_if.data !== 8'h22) begin bad++; $display("FAIL mrst_pre got %h want 22", m_if.data); end
        rst = 1'b1;
        step(8'h5A, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got %b want 0", m_if.valid); end
        total++; if (m_if.data !== 8'h00) begin bad++; $display("FAIL mrst_data got %h want 00", m_if.data); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mrst_locked got %b want 0", locked); end
        test_first_bytes("mrst");
    endtask

    initial begin
        s_if.data  = 8'h00;
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        scr_hist   = '0;
        test_reset();
        test_first_bytes("first");
        test_zero_stream();
        test_payload();
        test_backpressure();
        test_sync_clr();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_descrambler.md
Name: xor_descrambler

Overview:
- Receive-side byte-stream descrambler for the self-synchronising PRBS7 scrambler (x^7 + x^6 + 1).
- Undoes the XOR whitening applied at the transmit end. Input and output are valid/ready streams.
- Includes a fill/lock state machine that drops bytes until the tap history has been built from real received data.
- Sits between the link deserialiser and the byte consumer.

Parameters:
- SYNC_BYTES, 1: number of input bytes consumed and discarded after reset or sync_clr, while the history fills (range 1..15).
- DATA_W, 8: byte width. Only 8 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- sync_clr  in  1  synchronous re-sync request. Clears history and returns to FILL.
- s_data  in  8  scrambled input byte. Bit 7 is first in time.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept an input byte.
- m_data  out  8  descrambled byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the output byte.
- locked  out  1  high in the LOCKED state.

Behaviour:
- Reset values: m_data=0, m_valid=0, locked=0, history h[6:0]=0, fill counter=0, state=FILL.
- Input handshake: a transfer occurs when s_valid && s_ready.
  - s_ready = !m_valid || m_ready (single output register, pass-through on pop).
  - s_ready is also high in FILL regardless of m_valid.
- Per-bit step, applied to bits 7 down to 0 of each accepted byte:
  - out_bit = in_bit ^ h[5] ^ h[6]
  - then h = {h[5:0], in_bit}
  - The history always shifts in received (scrambled) bits.
- States:
  - FILL: every accepted byte updates h, produces no output, and increments the fill counter. When the counter reaches SYNC_BYTES on an accepted byte, go to LOCKED on the next cycle.
  - LOCKED: every accepted byte updates h and loads m_data with the descrambled byte; m_valid=1 the next cycle. Latency is 1 cycle from accept to m_valid.
- Output handshake:
  - m_valid clears on m_ready && !(new accept).
  - Accept plus pop in the same cycle: the new byte replaces the old one and m_valid stays 1.
  - m_data is stable while m_valid && !m_ready.
- sync_clr has priority over an input transfer in the same cycle. The input byte is still acknowledged (s_ready as computed) but discarded.
  - Effects: h=0, counter=0, state=FILL, locked=0, m_valid=0.
  - A pending output byte is dropped.
- rst has priority over everything. Mid-stream reset is identical in effect to power-on reset.
- No input transfer: h and state hold.
- Fill counter saturates at SYNC_BYTES; it never wraps.

Optional Feature:
- Macro: XOR_DESCR_BYPASS_EN. When defined, adds an input port bypass (1 bit).
- With bypass=1:
  - s_data is copied to m_data unchanged, with the same 1-cycle latency and handshake.
  - h still updates and the FILL/LOCKED sequencing still runs.
  - In FILL, bytes are emitted rather than dropped.
- Without the macro: the port is absent and behaviour is descramble-only.

Decomposition:
- Package xor_descr_pkg holds:
  - HIST_W=7, TAP_A=5, TAP_B=6 (history indices)
  - state enum {FILL, LOCKED}
  - a function golden_scramble_byte(byte, hist) used by the bench.
- Sub-module xor_descr_byte: purely combinational 8-bit step. Inputs are the byte and h; outputs are the descrambled byte and next h.
- The FSM and handshake live in xor_descrambler.

Test Plan:
- Reset, then bytes 0x00, 0xFF with m_ready=1 -> 0x00 is dropped (FILL), locked=1, and the next output is m_data=0xFD with m_valid one cycle after accept.
- 64 bytes of all-zero input after lock -> all outputs 0x00, no gaps when s_valid and m_ready are continuously high.
- Scramble random payload with golden_scramble_byte (hist=0), send 1 sync byte plus 200 bytes -> output equals payload byte-for-byte.
- Hold m_ready=0 for 3 cycles with a byte in m_data -> m_data stable, s_ready=0, no input consumed; release -> throughput resumes without loss.
- sync_clr mid-stream at byte 50 -> m_valid=0, locked=0 next cycle; the following byte is dropped; the stream resumes correctly when the scrambler is re-seeded identically.
- rst asserted for 1 cycle mid-transfer -> all outputs return to reset values; a repeat of scenario 1 gives 0xFD.
